// File: rtl/morse_symbol_tx.sv
// Morse transmitter: keys one packed 4-symbol character with standard unit timing.
// Define MORSE_TX_SYM_ECHO_EN to echo the raw symbols on sym_out/sym_load for loopback.
module morse_symbol_tx #(
   parameter int UNIT_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   input  logic [7:0] in_data,
   output logic       in_ready,
   output logic       key,
   output logic       busy,
   output logic       done,
   output logic [1:0] sym_out,
   output logic       sym_load
);

   localparam int CW = $clog2(3 * UNIT_CYCLES);
   localparam logic [CW-1:0] CNT_ONE   = CW'(UNIT_CYCLES - 1);
   localparam logic [CW-1:0] CNT_THREE = CW'(3 * UNIT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MARK = 2'd1,
      GAP  = 2'd2
   } state_t;

   state_t        state, state_next;
   logic [CW-1:0] cnt, cnt_next;
   logic [7:0]    shreg, shreg_next;
   logic [1:0]    idx, idx_next;
   logic          long_gap, long_gap_next;
   logic          done_next;
   logic          accept;
   logic          next_is_elem;

   function automatic logic is_elem(input logic [1:0] s);
      return (s == 2'b01) || (s == 2'b10);
   endfunction

   assign in_ready = (state == IDLE);
   assign busy     = ~in_ready;
   assign key      = (state == MARK);
   assign accept   = in_valid && in_ready;

   // The current symbol always sits in shreg[7:6]; its successor in [5:4].
   assign next_is_elem = (idx != 2'd3) && is_elem(shreg[5:4]);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         cnt      <= '0;
         shreg    <= '0;
         idx      <= '0;
         long_gap <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= state_next;
         cnt      <= cnt_next;
         shreg    <= shreg_next;
         idx      <= idx_next;
         long_gap <= long_gap_next;
         done     <= done_next;
      end
   end

   always_comb begin
      state_next    = state;
      cnt_next      = cnt;
      shreg_next    = shreg;
      idx_next      = idx;
      long_gap_next = long_gap;
      done_next     = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               shreg_next = in_data;
               idx_next   = 2'd0;
               if (is_elem(in_data[7:6])) begin
                  state_next = MARK;
                  cnt_next   = (in_data[7:6] == 2'b10) ? CNT_THREE : CNT_ONE;
               end else begin
                  done_next = 1'b1;
               end
            end
         end
         MARK: begin
            if (cnt == '0) begin
               state_next    = GAP;
               long_gap_next = !next_is_elem;
               cnt_next      = next_is_elem ? CNT_ONE : CNT_THREE;
            end else begin
               cnt_next = cnt - 1'b1;
            end
         end
         GAP: begin
            if (cnt == '0) begin
               // A long gap closes the character; a short one advances to the next symbol.
               if (long_gap) begin
                  state_next    = IDLE;
                  done_next     = 1'b1;
                  shreg_next    = '0;
                  idx_next      = 2'd0;
                  long_gap_next = 1'b0;
               end else begin
                  state_next = MARK;
                  shreg_next = {shreg[5:0], 2'b00};
                  idx_next   = idx + 2'd1;
                  cnt_next   = (shreg[5:4] == 2'b10) ? CNT_THREE : CNT_ONE;
               end
            end else begin
               cnt_next = cnt - 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
      endcase
   end

`ifdef MORSE_TX_SYM_ECHO_EN
   logic [5:0] echo_reg;
   logic [1:0] echo_left;

   // Echo replays all four raw symbols, end codes included, independent of keying.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         echo_reg  <= '0;
         echo_left <= '0;
         sym_out   <= 2'b00;
         sym_load  <= 1'b0;
      end else if (accept) begin
         sym_out   <= in_data[7:6];
         sym_load  <= 1'b1;
         echo_reg  <= in_data[5:0];
         echo_left <= 2'd3;
      end else if (echo_left != 2'd0) begin
         sym_out   <= echo_reg[5:4];
         sym_load  <= 1'b1;
         echo_reg  <= {echo_reg[3:0], 2'b00};
         echo_left <= echo_left - 2'd1;
      end else begin
         sym_out  <= 2'b00;
         sym_load <= 1'b0;
      end
   end
`else
   assign sym_out  = 2'b00;
   assign sym_load = 1'b0;
`endif

endmodule

// File: tb/tb_morse_symbol_tx.sv
// Directed bench for morse_symbol_tx: U=4 instance for keyed timing, U=1 instance for the empty case.
module tb_morse_symbol_tx;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid, in_valid1;
   logic [7:0] in_data, in_data1;
   logic       in_ready, key, busy, done, sym_load;
   logic [1:0] sym_out;
   logic       in_ready1, key1, busy1, done1, sym_load1;
   logic [1:0] sym_out1;

   int checks = 0;
   int errors = 0;

   logic       key_t   [0:127];
   logic       done_t  [0:127];
   logic       ready_t [0:127];
   logic       busy_t  [0:127];
   logic       load_t  [0:127];
   logic [1:0] symo_t  [0:127];

   morse_symbol_tx #(.UNIT_CYCLES(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .key(key), .busy(busy), .done(done),
      .sym_out(sym_out), .sym_load(sym_load)
   );

   morse_symbol_tx #(.UNIT_CYCLES(1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid1), .in_data(in_data1),
      .in_ready(in_ready1), .key(key1), .busy(busy1), .done(done1),
      .sym_out(sym_out1), .sym_load(sym_load1)
   );

   always #5 clk = ~clk;

   task automatic sample(input bit u1, input int c);
      if (u1) begin
         key_t[c] = key1;  done_t[c] = done1;  ready_t[c] = in_ready1;
         busy_t[c] = busy1; load_t[c] = sym_load1; symo_t[c] = sym_out1;
      end else begin
         key_t[c] = key;   done_t[c] = done;   ready_t[c] = in_ready;
         busy_t[c] = busy;  load_t[c] = sym_load;  symo_t[c] = sym_out;
      end
   endtask

   // Offer one character for a single handshake and record the following cycles.
   task automatic applyStimulus(input bit u1, input logic [7:0] data, input int ncycles);
      @(negedge clk);
      if (u1) begin in_valid1 = 1'b1; in_data1 = data; end
      else    begin in_valid  = 1'b1; in_data  = data; end
      @(posedge clk);
      for (int c = 1; c <= ncycles; c++) begin
         @(negedge clk);
         if (c == 1) begin in_valid = 1'b0; in_valid1 = 1'b0; end
         sample(u1, c);
      end
   endtask

   task automatic test_reset;
      rst = 1'b0; in_valid = 1'b0; in_valid1 = 1'b0; in_data = '0; in_data1 = '0;
      #12;
      checks++;
      if ({in_ready, busy, key, done, sym_out, sym_load} !== 7'b1000000) begin
         errors++;
         $display("[TB] FAIL reset_u4 got %b exp 1000000", {in_ready, busy, key, done, sym_out, sym_load});
      end
      checks++;
      if ({in_ready1, busy1, key1, done1, sym_out1, sym_load1} !== 7'b1000000) begin
         errors++;
         $display("[TB] FAIL reset_u1 got %b exp 1000000", {in_ready1, busy1, key1, done1, sym_out1, sym_load1});
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({in_ready, key, done} !== 3'b100) begin
         errors++;
         $display("[TB] FAIL post_reset got %b exp 100", {in_ready, key, done});
      end
   endtask

   task automatic test_char_a;
      logic [7:0] w = 8'b01_10_00_00;
      logic ek, ed, er, el;
      logic [1:0] es;
      applyStimulus(1'b0, w, 36);
      for (int c = 1; c <= 36; c++) begin
         ek = (c >= 1 && c <= 4) || (c >= 9 && c <= 20);
         ed = (c == 33);
         er = (c >= 33);
`ifdef MORSE_TX_SYM_ECHO_EN
         el = (c <= 4);
         es = (c <= 4) ? w[7-2*(c-1) -: 2] : 2'b00;
`else
         el = 1'b0;
         es = 2'b00;
`endif
         checks++;
         if (key_t[c] !== ek) begin errors++; $display("[TB] FAIL a_key cycle %0d got %b exp %b", c, key_t[c], ek); end
         checks++;
         if (done_t[c] !== ed) begin errors++; $display("[TB] FAIL a_done cycle %0d got %b exp %b", c, done_t[c], ed); end
         checks++;
         if (ready_t[c] !== er || busy_t[c] !== !er) begin
            errors++; $display("[TB] FAIL a_ready cycle %0d got %b/%b exp %b", c, ready_t[c], busy_t[c], er);
         end
         checks++;
         if (load_t[c] !== el || symo_t[c] !== es) begin
            errors++; $display("[TB] FAIL a_echo cycle %0d got %b/%b exp %b/%b", c, load_t[c], symo_t[c], el, es);
         end
      end
   endtask

   task automatic test_four_dots;
      logic ek, ed, er;
      applyStimulus(1'b0, 8'b01_01_01_01, 44);
      for (int c = 1; c <= 44; c++) begin
         ek = (c >= 1 && c <= 4) || (c >= 9 && c <= 12) || (c >= 17 && c <= 20) || (c >= 25 && c <= 28);
         ed = (c == 41);
         er = (c >= 41);
         checks++;
         if (key_t[c] !== ek) begin errors++; $display("[TB] FAIL dots_key cycle %0d got %b exp %b", c, key_t[c], ek); end
         checks++;
         if (done_t[c] !== ed || ready_t[c] !== er) begin
            errors++; $display("[TB] FAIL dots_done cycle %0d got %b/%b exp %b/%b", c, done_t[c], ready_t[c], ed, er);
         end
      end
   endtask

   task automatic test_empty_u1;
      logic [7:0] w = 8'b00_10_10_10;
      logic el;
      logic [1:0] es;
      applyStimulus(1'b1, w, 6);
      for (int c = 1; c <= 6; c++) begin
`ifdef MORSE_TX_SYM_ECHO_EN
         el = (c <= 4);
         es = (c <= 4) ? w[7-2*(c-1) -: 2] : 2'b00;
`else
         el = 1'b0;
         es = 2'b00;
`endif
         checks++;
         if (key_t[c] !== 1'b0 || ready_t[c] !== 1'b1) begin
            errors++; $display("[TB] FAIL empty_key cycle %0d got key %b ready %b exp 0/1", c, key_t[c], ready_t[c]);
         end
         checks++;
         if (done_t[c] !== (c == 1)) begin
            errors++; $display("[TB] FAIL empty_done cycle %0d got %b exp %b", c, done_t[c], (c == 1));
         end
         checks++;
         if (load_t[c] !== el || symo_t[c] !== es) begin
            errors++; $display("[TB] FAIL empty_echo cycle %0d got %b/%b exp %b/%b", c, load_t[c], symo_t[c], el, es);
         end
      end
   endtask

   task automatic test_echo_empty;
      logic el;
      logic [1:0] es;
      logic [1:0] exp_syms [0:3];
      exp_syms[0] = 2'b11; exp_syms[1] = 2'b01; exp_syms[2] = 2'b10; exp_syms[3] = 2'b00;
      applyStimulus(1'b0, 8'b11_01_10_00, 6);
      for (int c = 1; c <= 6; c++) begin
`ifdef MORSE_TX_SYM_ECHO_EN
         el = (c <= 4);
         es = (c <= 4) ? exp_syms[c-1] : 2'b00;
`else
         el = 1'b0;
         es = 2'b00;
`endif
         checks++;
         if (key_t[c] !== 1'b0 || done_t[c] !== (c == 1)) begin
            errors++; $display("[TB] FAIL echo_key cycle %0d got key %b done %b", c, key_t[c], done_t[c]);
         end
         checks++;
         if (load_t[c] !== el || symo_t[c] !== es) begin
            errors++; $display("[TB] FAIL echo_sym cycle %0d got %b/%b exp %b/%b", c, load_t[c], symo_t[c], el, es);
         end
      end
   endtask

   task automatic test_back_to_back;
      logic ek, ed, er, el;
      logic [1:0] es;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'b01_10_00_00;
      @(posedge clk);
      for (int c = 1; c <= 60; c++) begin
         @(negedge clk);
         if (c == 1)  in_data  = 8'b10_00_00_00;
         if (c == 34) in_valid = 1'b0;
         sample(1'b0, c);
      end
      for (int c = 1; c <= 60; c++) begin
         ek = (c >= 1 && c <= 4) || (c >= 9 && c <= 20) || (c >= 34 && c <= 45);
         ed = (c == 33) || (c == 58);
         er = (c == 33) || (c >= 58);
`ifdef MORSE_TX_SYM_ECHO_EN
         el = (c >= 1 && c <= 4) || (c >= 34 && c <= 37);
         es = (c == 1) ? 2'b01 : (c == 2) ? 2'b10 : (c == 34) ? 2'b10 : 2'b00;
`else
         el = 1'b0;
         es = 2'b00;
`endif
         checks++;
         if (key_t[c] !== ek) begin errors++; $display("[TB] FAIL b2b_key cycle %0d got %b exp %b", c, key_t[c], ek); end
         checks++;
         if (done_t[c] !== ed || ready_t[c] !== er) begin
            errors++; $display("[TB] FAIL b2b_done cycle %0d got %b/%b exp %b/%b", c, done_t[c], ready_t[c], ed, er);
         end
         checks++;
         if (load_t[c] !== el || symo_t[c] !== es) begin
            errors++; $display("[TB] FAIL b2b_echo cycle %0d got %b/%b exp %b/%b", c, load_t[c], symo_t[c], el, es);
         end
      end
   endtask

   task automatic test_reset_mid;
      logic ek, ed, er;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'b01_10_00_00;
      @(posedge clk);
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (c == 1) in_valid = 1'b0;
      end
      checks++;
      if (key !== 1'b1) begin errors++; $display("[TB] FAIL mid_pre_key got %b exp 1", key); end
      rst = 1'b0;
      #1;
      checks++;
      if ({key, in_ready, busy, done} !== 4'b0100) begin
         errors++; $display("[TB] FAIL mid_async got %b exp 0100", {key, in_ready, busy, done});
      end
      @(negedge clk);
      rst = 1'b1;
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk);
         checks++;
         if ({key, in_ready, done} !== 3'b010) begin
            errors++; $display("[TB] FAIL mid_quiet cycle %0d got %b exp 010", c, {key, in_ready, done});
         end
      end
      applyStimulus(1'b0, 8'b10_00_00_00, 28);
      for (int c = 1; c <= 28; c++) begin
         ek = (c <= 12);
         ed = (c == 25);
         er = (c >= 25);
         checks++;
         if (key_t[c] !== ek || done_t[c] !== ed || ready_t[c] !== er) begin
            errors++;
            $display("[TB] FAIL mid_after cycle %0d got %b%b%b exp %b%b%b", c, key_t[c], done_t[c], ready_t[c], ek, ed, er);
         end
      end
   endtask

   initial begin
      test_reset();
      test_char_a();
      test_four_dots();
      test_empty_u1();
      test_echo_empty();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
